// File: rtl/vesa_pattern_pkg.sv
// rtl/vesa_pattern_pkg.sv - shared constants and types for the VESA test-pattern generator
//
// Contents:
//   pat_e            pattern codes PAT_BLACK..PAT_RSVD (3-bit)
//   *_DEF            default geometry for H_ACTIVE, V_ACTIVE, BAR_W
//   X_W / Y_W        pixel and line counter widths
//   COL_*            24-bit {r,g,b} colours used by the bar pattern
//   bar_colour()     maps a bar index 0..7 to its colour
//   CRC_POLY/INIT    CRC-16-CCITT constants for the optional frame CRC
package vesa_pattern_pkg;

  localparam int H_ACTIVE_DEF = 2560;
  localparam int V_ACTIVE_DEF = 1440;
  localparam int BAR_W_DEF    = 32;

  localparam int X_W = 12;
  localparam int Y_W = 11;

  typedef enum logic [2:0] {
    PAT_BLACK   = 3'd0,
    PAT_WHITE   = 3'd1,
    PAT_BARS    = 3'd2,
    PAT_RAMP    = 3'd3,
    PAT_CHECKER = 3'd4,
    PAT_MOVBAR  = 3'd5,
    PAT_BORDER  = 3'd6,
    PAT_RSVD    = 3'd7
  } pat_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Colour-bar order, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vesa_crc16.sv
// rtl/vesa_crc16.sv - combinational CRC-16-CCITT update over one 24-bit pixel
//
// Only compiled when VESA_PATTERN_FRAME_CRC_EN is defined; otherwise the
// file contributes no module so no CRC logic exists in the build.
//
// Ports:
//   crc_in   [15:0]  running CRC before this pixel
//   data     [23:0]  pixel {r,g,b}, absorbed MSB first
//   crc_out  [15:0]  running CRC after this pixel
`ifdef VESA_PATTERN_FRAME_CRC_EN
module vesa_crc16
  import vesa_pattern_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Bit-serial shift unrolled across all 24 data bits (no reflection).
  always_comb begin
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
  end

  assign crc_out = c;

endmodule
`endif

// File: rtl/vesa_pattern_gen.sv
// rtl/vesa_pattern_gen.sv - VESA test-pattern generator with optional frame CRC
//
// Optional feature macro: VESA_PATTERN_FRAME_CRC_EN (frame CRC over output pixels).
//
// Ports:
//   clk                    pixel clock
//   rst                    synchronous active-high reset
//   hsync_in, vsync_in     timing syncs, active-low
//   de_in                  timing data enable
//   pattern_sel [2:0]      requested pattern, taken at frame start
//   hsync_out, vsync_out   syncs delayed 2 clk
//   de_out                 data enable delayed 2 clk
//   r_out, g_out, b_out    pixel colour, 0 while de_out=0
//   frame_cnt [7:0]        frame starts seen since reset (wraps)
//   frame_crc [15:0]       CRC of previous frame's active pixels (0 without macro)
//   crc_valid              1-clk pulse when frame_crc updates (0 without macro)
module vesa_pattern_gen
  import vesa_pattern_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BAR_W    = BAR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [2:0]  pattern_sel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [7:0]  frame_cnt,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam int              BAR_SPAN = H_ACTIVE / 8;
  localparam logic [X_W-1:0]  X_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [X_W-1:0]  X_MAX    = '1;

  logic           vsync_d1;
  logic           de_d1;
  logic           frame_start;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  pat_e           active_sel;
  logic [7:0]     frame_cnt_q;

  logic [2:0]     bar_idx;
  logic [X_W-1:0] bar_lo;
  logic [X_W-1:0] bar_hi;
  logic [23:0]    pix;

  logic           s1_hs, s1_vs, s1_de;
  logic [23:0]    s1_rgb;
  logic           s2_hs, s2_vs, s2_de;
  logic [23:0]    s2_rgb;

  // Frame start is the falling edge of the (active-low) vsync.
  assign frame_start = vsync_d1 & ~vsync_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d1 <= 1'b1;
      de_d1    <= 1'b0;
    end else begin
      vsync_d1 <= vsync_in;
      de_d1    <= de_in;
    end
  end

  // Pixel counter: the colour for this clock uses the value before the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
    end else if (!de_in) begin
      x <= '0;
    end else if (x != X_MAX) begin
      x <= x + 1'b1;
    end
  end

  // Line counter: advances at the end of each active line; frame start wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (frame_start) begin
      y <= '0;
    end else if (de_d1 && !de_in) begin
      y <= y + 1'b1;
    end
  end

  // Pattern choice is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_sel  <= PAT_BLACK;
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      active_sel  <= pat_e'(pattern_sel);
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Bar index from a chain of threshold compares; lowest matching bar wins.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (x < X_W'((i + 1) * BAR_SPAN)) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Moving bar starts 8 px further right every frame.
  assign bar_lo = X_W'({frame_cnt_q, 3'b000});
  assign bar_hi = bar_lo + X_W'(BAR_W);

  always_comb begin
    pix = COL_BLACK;
    case (active_sel)
      PAT_BLACK:   pix = COL_BLACK;
      PAT_WHITE:   pix = COL_WHITE;
      PAT_BARS:    pix = bar_colour(bar_idx);
      PAT_RAMP:    pix = {3{x[7:0]}};
      PAT_CHECKER: pix = (x[6] ^ y[6]) ? COL_WHITE : COL_BLACK;
      PAT_MOVBAR:  pix = (x >= bar_lo && x < bar_hi) ? COL_WHITE : COL_BLACK;
      PAT_BORDER:  pix = (x == '0 || x == X_LAST || y == '0 || y == Y_LAST) ?
                         COL_WHITE : COL_BLACK;
      default:     pix = COL_BLACK;
    endcase
  end

  // Two-stage output pipeline; blanking applied in stage 1 keeps rgb at 0
  // whenever the delayed de is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_de  <= 1'b0;
      s1_rgb <= '0;
      s2_hs  <= 1'b1;
      s2_vs  <= 1'b1;
      s2_de  <= 1'b0;
      s2_rgb <= '0;
    end else begin
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
      s1_de  <= de_in;
      s1_rgb <= de_in ? pix : '0;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;
      s2_rgb <= s1_rgb;
    end
  end

  assign hsync_out = s2_hs;
  assign vsync_out = s2_vs;
  assign de_out    = s2_de;
  assign r_out     = s2_rgb[23:16];
  assign g_out     = s2_rgb[15:8];
  assign b_out     = s2_rgb[7:0];
  assign frame_cnt = frame_cnt_q;

`ifdef VESA_PATTERN_FRAME_CRC_EN
  logic [15:0] crc_run;
  logic [15:0] crc_next;
  logic [15:0] frame_crc_q;
  logic        crc_valid_q;

  vesa_crc16 u_crc16 (
    .crc_in  (crc_run),
    .data    (s2_rgb),
    .crc_out (crc_next)
  );

  // Frame start snapshots and restarts the CRC; a pixel leaving the pipe on
  // that same clock is dropped rather than counted in either frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_run     <= CRC_INIT;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else if (frame_start) begin
      frame_crc_q <= crc_run;
      crc_valid_q <= 1'b1;
      crc_run     <= CRC_INIT;
    end else begin
      crc_valid_q <= 1'b0;
      if (s2_de) begin
        crc_run <= crc_next;
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vesa_pattern_gen.sv
// tb/tb_vesa_pattern_gen.sv - self-checking bench for vesa_pattern_gen
module tb_vesa_pattern_gen;

  localparam int H  = 2560;
  localparam int V  = 1440;
  localparam int BW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, de_in;
  logic [2:0]  pattern_sel;
  logic        hsync_out, vsync_out, de_out;
  logic [7:0]  r_out, g_out, b_out;
  logic [7:0]  frame_cnt;
  logic [15:0] frame_crc;
  logic        crc_valid;

  always #5 clk = ~clk;

  vesa_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .de_in       (de_in),
    .pattern_sel (pattern_sel),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de_out      (de_out),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .frame_cnt   (frame_cnt),
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state: frame-level view of the video stream.
  int          m_x, m_y, m_fcnt;
  logic [2:0]  m_sel;
  logic        m_vs_prev, m_de_prev;
  logic [26:0] pipe1, pipe2;
  logic [15:0] m_run, m_crc;
  logic        m_valid;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] line_px [8192];
  int          out_x = 0;

  function automatic logic [23:0] ref_pix(input int sel, input int x, input int y, input int fc);
    int b;
    case (sel)
      1: return 24'hFFFFFF;
      2: begin
        b = x / (H / 8);
        if (b > 7) b = 7;
        return bars[b];
      end
      3: return {3{8'(x % 256)}};
      4: return ((((x / 64) + (y / 64)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      5: return (x >= fc * 8 && x < fc * 8 + BW) ? 24'hFFFFFF : 24'h0;
      6: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_fcnt = 0; m_sel = 3'd0;
    m_vs_prev = 1'b1; m_de_prev = 1'b0;
    pipe1 = {3'b110, 24'h0}; pipe2 = {3'b110, 24'h0};
    m_run = 16'hFFFF; m_crc = 16'h0; m_valid = 1'b0;
  endtask

  task automatic step(input logic hs, input logic vs, input logic de, input logic [2:0] sel);
    logic        fs;
    logic [23:0] px;
    hsync_in = hs; vsync_in = vs; de_in = de; pattern_sel = sel;
    fs = m_vs_prev & ~vs;
    px = de ? ref_pix(int'(m_sel), m_x, m_y, m_fcnt) : 24'h0;
`ifdef VESA_PATTERN_FRAME_CRC_EN
    m_valid = 1'b0;
    if (fs) begin
      m_crc = m_run; m_valid = 1'b1; m_run = 16'hFFFF;
    end else if (pipe2[24]) begin
      m_run = crc_byte(m_run, pipe2[23:16]);
      m_run = crc_byte(m_run, pipe2[15:8]);
      m_run = crc_byte(m_run, pipe2[7:0]);
    end
`endif
    pipe2 = pipe1;
    pipe1 = {hs, vs, de, px};
    m_x = de ? ((m_x < 4095) ? m_x + 1 : 4095) : 0;
    if (fs) begin
      m_y = 0; m_sel = sel; m_fcnt = (m_fcnt + 1) % 256;
    end else if (m_de_prev && !de) begin
      m_y = (m_y + 1) % 2048;
    end
    m_vs_prev = vs; m_de_prev = de;
    @(posedge clk); #1;
    check("pix", {hsync_out, vsync_out, de_out, r_out, g_out, b_out}, pipe2);
    check("frame_cnt", frame_cnt, m_fcnt);
    check("crc", {crc_valid, frame_crc}, {m_valid, m_crc});
    if (de_out) begin
      if (out_x < 8192) line_px[out_x] = {r_out, g_out, b_out};
      out_x++;
    end else begin
      out_x = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; pattern_sel = 3'd0;
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_out", {hsync_out, vsync_out, de_out, r_out, g_out, b_out}, {3'b110, 24'h0});
      check("rst_cnt", {frame_cnt, crc_valid, frame_crc}, 25'h0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame_start_seq(input logic [2:0] sel);
    step(1, 1, 0, sel);
    step(1, 0, 0, sel);
    step(1, 0, 0, sel);
    step(1, 1, 0, sel);
  endtask

  task automatic line(input int n, input logic [2:0] sel);
    step(0, 1, 0, sel);
    step(1, 1, 0, sel);
    for (int i = 0; i < n; i++) step(1, 1, 1, sel);
    step(1, 1, 0, sel);
    step(1, 1, 0, sel);
  endtask

  typedef struct {
    logic [2:0]  sel;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [15:0] crc_zero;
    int          st;

    vecs[0]  = '{3'd2, 0,    0,    24'hFFFFFF};
    vecs[1]  = '{3'd2, 319,  0,    24'hFFFFFF};
    vecs[2]  = '{3'd2, 320,  0,    24'hFFFF00};
    vecs[3]  = '{3'd2, 2240, 0,    24'h000000};
    vecs[4]  = '{3'd2, 960,  0,    24'h00FF00};
    vecs[5]  = '{3'd3, 200,  3,    24'hC8C8C8};
    vecs[6]  = '{3'd4, 63,   0,    24'h000000};
    vecs[7]  = '{3'd4, 64,   0,    24'hFFFFFF};
    vecs[8]  = '{3'd4, 64,   64,   24'h000000};
    vecs[9]  = '{3'd4, 0,    64,   24'hFFFFFF};
    vecs[10] = '{3'd6, 0,    5,    24'hFFFFFF};
    vecs[11] = '{3'd6, 2559, 5,    24'hFFFFFF};
    vecs[12] = '{3'd6, 1000, 0,    24'hFFFFFF};
    vecs[13] = '{3'd6, 1000, 1439, 24'hFFFFFF};
    vecs[14] = '{3'd6, 1000, 1438, 24'h000000};
    vecs[15] = '{3'd6, 2558, 5,    24'h000000};
    vecs[16] = '{3'd1, 7,    2,    24'hFFFFFF};
    vecs[17] = '{3'd0, 7,    2,    24'h000000};
    vecs[18] = '{3'd7, 7,    2,    24'h000000};

    do_reset();

    // First frame start from reset.
    frame_start_seq(3'd0);
    check("first_frame_cnt", frame_cnt, 8'd1);

    // Two-clock latency of de and vsync.
    step(1, 1, 1, 3'd0);
    check("de_lat0", de_out, 1'b0);
    step(1, 1, 0, 3'd0);
    check("de_lat1", de_out, 1'b1);
    step(1, 1, 0, 3'd0);
    check("de_lat2", de_out, 1'b0);
    step(1, 0, 0, 3'd0);
    check("vs_lat0", vsync_out, 1'b1);
    step(1, 1, 0, 3'd0);
    check("vs_lat1", vsync_out, 1'b0);
    step(1, 1, 0, 3'd0);
    check("vs_lat2", vsync_out, 1'b1);

    // Table: pattern pixel at (x,y) in a fresh frame.
    for (int v = 0; v < 19; v++) begin
      frame_start_seq(vecs[v].sel);
      for (int l = 0; l < vecs[v].y; l++) line(1, vecs[v].sel);
      line(vecs[v].x + 1, vecs[v].sel);
      check($sformatf("table%0d", v), line_px[vecs[v].x], vecs[v].exp);
    end

    // Mid-frame pattern_sel change is ignored until the next frame.
    frame_start_seq(3'd4);
    line(65, 3'd1);
    check("chk_hold0", line_px[0], 24'h000000);
    check("chk_hold64", line_px[64], 24'hFFFFFF);
    frame_start_seq(3'd1);
    line(1, 3'd1);
    check("sel_switch", line_px[0], 24'hFFFFFF);

    // x saturates at 4095.
    frame_start_seq(3'd3);
    line(4100, 3'd3);
    check("sat4094", line_px[4094], 24'hFEFEFE);
    check("sat4095", line_px[4095], 24'hFFFFFF);
    check("sat4099", line_px[4099], 24'hFFFFFF);

    // Moving bar across three frames from reset.
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      st = f * 8;
      frame_start_seq(3'd5);
      line(st + BW + 1, 3'd5);
      check($sformatf("bar%0d_pre", f), line_px[st - 1], 24'h000000);
      check($sformatf("bar%0d_lo", f), line_px[st], 24'hFFFFFF);
      check($sformatf("bar%0d_hi", f), line_px[st + BW - 1], 24'hFFFFFF);
      check($sformatf("bar%0d_post", f), line_px[st + BW], 24'h000000);
    end

    // frame_cnt wraps after 256 frame starts.
    do_reset();
    for (int f = 0; f < 256; f++) frame_start_seq(3'd0);
    check("cnt_wrap", frame_cnt, 8'd0);

    // Frame CRC over 2 lines x 4 black pixels = 24 zero bytes.
    do_reset();
    crc_zero = 16'hFFFF;
    for (int k = 0; k < 24; k++) crc_zero = crc_byte(crc_zero, 8'h00);
    frame_start_seq(3'd0);
    line(4, 3'd0);
    line(4, 3'd0);
    step(1, 1, 0, 3'd0);
    step(1, 0, 0, 3'd0);
`ifdef VESA_PATTERN_FRAME_CRC_EN
    check("crc_zero", frame_crc, crc_zero);
    check("crc_valid_hi", crc_valid, 1'b1);
    step(1, 0, 0, 3'd0);
    check("crc_valid_lo", crc_valid, 1'b0);
`else
    check("crc_off", frame_crc, 16'h0);
    check("crc_valid_off", crc_valid, 1'b0);
    step(1, 0, 0, 3'd0);
    check("crc_valid_off2", crc_valid, 1'b0);
`endif
    step(1, 1, 0, 3'd0);

    // Randomized frames, including a reset in the middle of a line.
    do_reset();
    for (int f = 0; f < 16; f++) begin
      logic [2:0] sel;
      int         nl;
      sel = 3'($urandom_range(0, 7));
      frame_start_seq(sel);
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) line($urandom_range(1, 300), 3'($urandom_range(0, 7)));
      if (f == 8) begin
        for (int i = 0; i < 10; i++) step(1, 1, 1, sel);
        do_reset();
        line(5, 3'd3);
        check("rst_sel0", line_px[4], 24'h000000);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
